// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, FSM state type and MSB helper for the sequential multiplier.
package mul_pkg;
    localparam int WIDTH = 16;
    localparam int ITERS = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Index of the highest set bit; 0 for a zero operand.
    function automatic logic [3:0] msb_idx(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = v[i] ? 4'(i) : r;
        return r;
    endfunction
endpackage

// File: rtl/cla.sv
// cla: 16-bit carry-lookahead adder.
//   a, b : addends    cin : carry in
//   sum  : 16-bit sum cout : carry out
module cla (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g, p;
    logic [16:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Generate/propagate recurrence; flattened into lookahead terms by synthesis.
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 16; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign sum  = p ^ c[15:0];
    assign cout = c[16];
endmodule

// File: rtl/mul_seq.sv
// mul_seq: sequential 16x16 unsigned shift-add multiplier driving one cla per iteration.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, a, b    : launch request and operands, captured when start is accepted
//   busy, done     : operation in progress / one-cycle completion pulse
//   product        : registered 32-bit result, held until the next completion
//   MUL_EARLY_EXIT_EN : when defined, RUN stops after the MSB of b and the result is realigned
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // {acc, low}; the carry bit above acc is always zero after the shift, so it is not stored.
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod_next;
    logic               last;

    cla u_cla (
        .a   (work_q[2*WIDTH-1:WIDTH]),
        .b   (work_q[0] ? mcand_q : '0),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    assign step = {cout, sum, work_q[WIDTH-1:1]};

`ifdef MUL_EARLY_EXIT_EN
    logic [3:0] msb_q, msb_d;

    assign last      = cnt_q == {1'b0, msb_q};
    // Skipped iterations would only shift right, so apply them in one step.
    assign prod_next = step >> (4'd15 - cnt_q[3:0]);
`else
    assign last      = cnt_q == CNT_W'(ITERS - 1);
    assign prod_next = step;
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MUL_EARLY_EXIT_EN
        msb_d     = msb_q;
`endif
        if (start && state_q != RUN) begin
            state_d = RUN;
            mcand_d = a;
            work_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
`ifdef MUL_EARLY_EXIT_EN
            msb_d   = msb_idx(b);
`endif
        end else if (state_q == RUN) begin
            work_d = step;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                state_d   = DONE;
                product_d = prod_next;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef MUL_EARLY_EXIT_EN
            msb_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef MUL_EARLY_EXIT_EN
            msb_q     <= msb_d;
`endif
        end
    end

    assign busy    = state_q == RUN;
    assign done    = state_q == DONE;
    assign product = product_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: randomized scoreboard bench for mul_seq (both MUL_EARLY_EXIT_EN builds).
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done;
    logic [31:0] product;

    always #5 clk = ~clk;

    mul_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    typedef struct {
        logic [31:0] p;
        int          lat;
        int          issue;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    int   busy_cnt = 0;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // RUN length: bits of b up to its MSB (at least one) when exiting early, else all 16.
    function automatic int rounds(input logic [15:0] bv);
        int k;
        k = (bv == 0) ? 1 : $clog2(int'(bv) + 1);
        return EARLY ? k : 16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, ncyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                check("busy_in_done", 32'(busy), 32'd0);
                if (q.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("product", product, e.p);
                    check("latency", 32'(ncyc - e.issue), 32'(e.lat + 1));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        q.push_back('{32'(av) * 32'(bv), rounds(bv), ncyc});
        tick;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 60 && q.size() != 0; i++) tick;
        if (q.size() != 0) begin
            check("timeout_pending", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic wait_done;
        int i;
        for (i = 0; i < 40 && !done; i++) tick;
        if (!done) check("timeout_done", 32'(done), 32'd1);
    endtask

    initial begin
        logic [15:0] av, bv;
        repeat (3) tick;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", product, 32'd0);
        rst_n = 1'b1;
        tick;

        issue(16'd3, 16'd5);
        wait_idle;
        tick;
        issue(16'hFFFF, 16'hFFFF);
        wait_idle;
        tick;
        issue(16'h8000, 16'h0002);
        wait_idle;
        tick;
        issue(16'h1234, 16'h0000);
        wait_idle;

        tick;
        issue(16'h1111, 16'h9001);
        repeat (4) tick;
        a = 16'd7;
        b = 16'd7;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_idle;
        repeat (20) tick;
        check("ignored_start_hold", product, 32'h1111 * 32'h9001);

        tick;
        issue(16'h0101, 16'h8003);
        wait_done;
        issue(16'd100, 16'd200);
        repeat (5) begin
            check("product_hold", product, 32'h0101 * 32'h8003);
            tick;
        end
        wait_idle;
        check("b2b_product", product, 32'd20000);

        tick;
        issue(16'hABCD, 16'hF00F);
        repeat (8) tick;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_product", product, 32'd0);
        q.delete();
        tick;
        rst_n = 1'b1;
        tick;
        issue(16'd9, 16'd9);
        wait_idle;

        for (int n = 0; n < 3000; n++) begin
            av = 16'($urandom);
            bv = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if ($urandom_range(0, 3) != 0) tick;
            issue(av, bv);
            wait_idle;
        end

        repeat (5) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
